// File: rtl/game_pkg.sv
// Shared gameplay definitions: event ids, event count, gameplay-state codes.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package game_pkg;

  // Event ids; the bit position in src_pulse equals the id.
  localparam int N_EV = 7;
  localparam logic [2:0] EV_HIT0   = 3'd0;
  localparam logic [2:0] EV_HIT1   = 3'd1;
  localparam logic [2:0] EV_HIT2   = 3'd2;
  localparam logic [2:0] EV_HIT3   = 3'd3;
  localparam logic [2:0] EV_DMG0   = 3'd4;
  localparam logic [2:0] EV_DMG1   = 3'd5;
  localparam logic [2:0] EV_TICKET = 3'd6;

  // Top-level game states; EASY..INFERNO are the states in which play is live.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EASY    = 3'd1,
    ST_NORMAL  = 3'd2,
    ST_HARD    = 3'd3,
    ST_INFERNO = 3'd4,
    ST_OVER    = 3'd5
  } game_state_e;

  // Derives the arbiter enable from the game state.
  function automatic logic is_gameplay(input game_state_e s);
    return (s >= ST_EASY) && (s <= ST_INFERNO);
  endfunction

endpackage

// File: rtl/hit_event_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from ptr+1, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to use the pick.
// Ports: req (request vector), ptr (last winner), any (some request set), win (winner index).
module rr_pick #(
  parameter int N  = 7,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] win
);

  int idx;

  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    // Offsets 1..N visit ptr+1 first and ptr itself last.
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/hit_event_arbiter.sv
// Serialises one-cycle event pulses into a valid/ready stream via per-source pending counters.
// Latency: pulse counted at edge t, presented after edge t+1; one event per cycle when ready.
// Backpressure: ev_valid/ev_id hold while !ev_ready; counters absorb bursts, overflow is counted.
// Ports: clk, rst (async active-low), src_pulse/enable/flush (inputs), ev_valid/ev_ready/ev_id
//        (event stream), pending (nonzero counters), drop_cnt/overflow (saturation losses).
module hit_event_arbiter
  import game_pkg::*;
#(
  parameter int N_SRC  = N_EV,
  parameter int CNT_W  = 3,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  src_pulse,
  input  logic              enable,
  input  logic              flush,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [2:0]        ev_id,
  output logic [N_SRC-1:0]  pending,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overflow
);

  localparam int                IW       = 3;
  localparam logic [IW-1:0]     PTR_RST  = IW'(N_SRC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [N_SRC];
  logic [CNT_W-1:0]  cnt_d [N_SRC];
  logic              full_q, full_d;
  logic [IW-1:0]     id_q, id_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;

  logic              any;
  logic [IW-1:0]     win;
  logic              slot_free;
  logic              load;
  logic [N_SRC-1:0]  grant;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      pending[i] = (cnt_q[i] != '0);
    end
  end

  rr_pick #(.N(N_SRC), .IW(IW)) u_rr_pick (
    .req (pending),
    .ptr (ptr_q),
    .any (any),
    .win (win)
  );

  // The slot can take a new event when empty or when its current event is
  // being accepted this cycle; flush suppresses any refill.
  assign slot_free = !full_q || ev_ready;
  assign load      = slot_free && any && !flush;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      grant[i] = load && (win == IW'(i));
    end
  end

  always_comb begin
    full_d = full_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;

    if (flush) begin
      full_d = 1'b0;
      ptr_d  = PTR_RST;
    end else if (load) begin
      full_d = 1'b1;
      id_d   = win;
      ptr_d  = win;
    end else if (full_q && ev_ready) begin
      full_d = 1'b0;
    end

    for (int i = 0; i < N_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (src_pulse[i] && enable) begin
        // A pulse coinciding with a grant of the same source replaces the
        // dequeued event, so even a saturated counter loses nothing.
        if (!grant[i]) begin
          if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end else begin
            ovf_d = 1'b1;
            if (drop_d != DROP_MAX) drop_d = drop_d + 1'b1;
          end
        end
      end else if (grant[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
      full_q <= 1'b0;
      id_q   <= '0;
      ptr_q  <= PTR_RST;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= cnt_d[i];
      full_q <= full_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ev_valid = full_q;
  assign ev_id    = id_q;
  assign drop_cnt = drop_q;
  assign overflow = ovf_q;

endmodule

// File: doc/hit_event_arbiter.md
# hit_event_arbiter

Collects the one-cycle gameplay event pulses (four lane hits, two damage strikes, one ticket) and presents them to the player/score logic as a serialized valid/ready event stream, one event per accepted transfer. Bursts are buffered in per-source saturating counters, so same-cycle events from different lanes are never lost. Sources are granted round-robin. The block sits between the one-pulse stage and `player`, and frees `player` from handling simultaneous pulses.

## Interface
Parameters:
- `N_SRC`, 7, number of event sources (bit index = event id)
- `CNT_W`, 3, width of each per-source pending counter (max 2^CNT_W−1 pending)
- `DROP_W`, 8, width of dropped-event counter

Ports:
- `clk`  in  1  system clock (100 MHz)
- `rst`  in  1  reset, asynchronous, active-low
- `src_pulse`  in  N_SRC  one-cycle event pulses; bit i = event id i
- `enable`  in  1  high during gameplay states; low = new pulses ignored
- `flush`  in  1  synchronous clear of queued events (state change)
- `ev_valid`  out  1  event available
- `ev_ready`  in  1  consumer accepts event this cycle
- `ev_id`  out  3  id of presented event
- `pending`  out  N_SRC  bit i = counter i nonzero
- `drop_cnt`  out  DROP_W  saturating count of events lost to counter saturation
- `overflow`  out  1  sticky, set on the first drop

## Operation
- Reset (rst=0) has these values: all counters 0, `ev_valid`=0, `ev_id`=0, `drop_cnt`=0, `overflow`=0, rr pointer=N_SRC−1, so the first search starts at id 0.
- Per-source counter i, each cycle:
  - Accepted pulse and no load of i: +1.
  - Load of i and no pulse: −1.
  - Both: unchanged.
- A pulse is accepted only when `enable`=1, `flush`=0, and the counter is below 2^CNT_W−1.
- A pulse arriving while the counter is saturated, with no same-cycle load of i: dropped. `drop_cnt` +1 (saturates at 2^DROP_W−1). `overflow` is set.
- Output slot has two states:
  - EMPTY: `ev_valid`=0.
  - FULL: `ev_valid`=1.
- Load condition is (EMPTY or (`ev_valid` and `ev_ready`)) and some counter is nonzero.
- Winner of a load: the first nonzero counter searching upward from pointer+1, mod N_SRC. The winner id is registered into `ev_id`, and the pointer is set to the winner.
- FULL with `ev_valid` and `ev_ready` and no load: slot goes to EMPTY.
- While FULL and not ready, `ev_valid` and `ev_id` hold stable.
- `flush`=1 has these effects: counters cleared, slot EMPTY, pointer set to N_SRC−1, same-cycle pulses discarded (not counted as drops). `drop_cnt` and `overflow` are kept.
- `enable`=0 does not stop draining; queued events are still delivered.

## Timing
- Pulse at edge t is counted at t. Earliest load is at edge t+1, so `ev_valid` is high after t+1. Latency is 1 cycle from counter update to presentation.
- Throughput with `ev_ready` held high: one event per cycle. No bubble between back-to-back events.
- `pending` is combinational from the counters. `ev_valid`, `ev_id`, `drop_cnt` and `overflow` are registered.
- Reset assertion mid-transfer drops `ev_valid` immediately (asynchronous). The consumer must not count that event.
- Simultaneous `flush` and handshake: the handshake completes (the consumer saw valid/ready), and nothing is reloaded.

## Structure
- Shared package `game_pkg` holds these items:
  - Event id constants: `EV_HIT0`=0..`EV_HIT3`=3, `EV_DMG0`=4, `EV_DMG1`=5, `EV_TICKET`=6.
  - `N_EV`=7.
  - Gameplay-state encodings used to derive `enable` (EASY..INFERNO).
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are a request vector and the pointer. Outputs are `any` and the winner index. It is instantiated once.
- The counter array and the output slot stay in the top of this block.

## Test plan
- Single pulse: `src_pulse`=7'b0000100 for 1 cycle, `ev_ready`=1. Response: `ev_valid` 1 cycle later with `ev_id`=2 for exactly 1 cycle; `pending` returns to 0.
- Burst: `src_pulse`=7'h7F for 1 cycle, `ev_ready`=1. Response: ids 0,1,2,3,4,5,6 on 7 consecutive cycles, `drop_cnt`=0.
- Backpressure and saturation: `ev_ready`=0, src 2 pulsed 9 consecutive cycles. Response: `ev_id`=2 held stable, counter 2 = 7, `drop_cnt`=1, `overflow`=1. Then `ev_ready`=1 delivers exactly 8 id-2 events.
- Fairness: src 0 pulsed every cycle, src 3 pulsed once, `ev_ready`=1. Response: id 3 is granted within 2 grants of its pulse, and id 0 continues afterwards.
- Enable/flush: `enable`=0 with pulses on src 1 gives no events and `drop_cnt` unchanged. Queue 3 events with `ev_ready`=0, then `flush`=1 for 1 cycle. Response: `ev_valid`=0, `pending`=0, and `drop_cnt` is unchanged.
- Async reset: assert `rst`=0 mid-stream between clock edges. Response: `ev_valid` falls before the next edge. After release, all outputs are 0, and the first new event comes from id 0 given simultaneous requests.
